cdec8_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single 256x8 synchronous program/data memory between the CDEC8 CPU core and a host port (program loader / debug monitor). It sits between the CPU's memory bus and the memory macro. It grants one access per cycle, returns read data with a registered acknowledge, and drives a stall to the CPU clock-enable whenever a CPU request is not granted. A host-burst limiter guarantees the CPU forward progress while the host is streaming.

---
 rtl/cdec8_mem_arbiter.sv | 101 ++++++++++
 tb/tb_cdec8_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdec8_mem_arbiter.sv
// cdec8_mem_arbiter: shares the 256x8 memory between the CPU core and host port.
// Define CDEC8_ARB_BURST_LIMIT_EN to bound host bursts while the CPU waits.
module cdec8_mem_arbiter #(
  parameter int unsigned HOST_BURST_MAX = 4
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_adrs,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_gnt,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  output logic       cpu_stall,
  input  logic       hst_req,
  input  logic       hst_we,
  input  logic [7:0] hst_adrs,
  input  logic [7:0] hst_wdata,
  output logic       hst_gnt,
  output logic       hst_ack,
  output logic [7:0] hst_rdata,
  input  logic       hst_halt,
  output logic [7:0] mem_adrs,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HST  = 2'd2
  } owner_e;

  localparam logic [3:0] BMAX = 4'(HOST_BURST_MAX);

  owner_e owner_q, owner_d;
  logic   cpu_slot;

  assign cpu_gnt   = cpu_req & ~hst_halt & (~hst_req | cpu_slot);
  assign hst_gnt   = hst_req & ~cpu_gnt;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    mem_adrs  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    owner_d   = OWN_NONE;
    unique case (1'b1)
      cpu_gnt: begin
        mem_adrs  = cpu_adrs;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        owner_d   = OWN_CPU;
      end
      hst_gnt: begin
        mem_adrs  = hst_adrs;
        mem_wdata = hst_wdata;
        mem_we    = hst_we;
        owner_d   = OWN_HST;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) owner_q <= OWN_NONE;
    else          owner_q <= owner_d;
  end

  assign cpu_ack   = (owner_q == OWN_CPU);
  assign hst_ack   = (owner_q == OWN_HST);
  assign cpu_rdata = cpu_ack ? mem_rdata : '0;
  assign hst_rdata = hst_ack ? mem_rdata : '0;

`ifdef CDEC8_ARB_BURST_LIMIT_EN
  logic [3:0] burst_q, burst_d;

  // Counts host grants the waiting CPU has lost; at the limit it gets a slot.
  assign cpu_slot = (burst_q == BMAX) & ~hst_halt;

  always_comb begin
    burst_d = burst_q;
    if (!cpu_req || cpu_gnt)
      burst_d = '0;
    else if (hst_gnt && (burst_q != BMAX))
      burst_d = burst_q + 4'd1;
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) burst_q <= '0;
    else          burst_q <= burst_d;
  end
`else
  logic unused_bmax;
  assign unused_bmax = ^BMAX;
  assign cpu_slot    = 1'b0;
`endif

endmodule

// File: tb/tb_cdec8_mem_arbiter.sv
// tb_cdec8_mem_arbiter: directed stimulus plus a per-cycle reference model
// of the arbiter and memory; follows CDEC8_ARB_BURST_LIMIT_EN like the DUT.
module tb_cdec8_mem_arbiter;

`ifdef CDEC8_ARB_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif
  localparam int HMAX = 4;

  logic       clock;
  logic       reset_N;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_ack, cpu_stall;
  logic [7:0] cpu_adrs, cpu_wdata, cpu_rdata;
  logic       hst_req, hst_we, hst_gnt, hst_ack, hst_halt;
  logic [7:0] hst_adrs, hst_wdata, hst_rdata;
  logic [7:0] mem_adrs, mem_wdata, mem_rdata;
  logic       mem_we;

  int n_chk = 0;
  int n_fail = 0;

  cdec8_mem_arbiter #(.HOST_BURST_MAX(HMAX)) dut (
    .clock(clock), .reset_N(reset_N),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adrs(cpu_adrs),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .hst_req(hst_req), .hst_we(hst_we), .hst_adrs(hst_adrs),
    .hst_wdata(hst_wdata), .hst_gnt(hst_gnt), .hst_ack(hst_ack),
    .hst_rdata(hst_rdata), .hst_halt(hst_halt),
    .mem_adrs(mem_adrs), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous 256x8 memory macro
  logic [7:0] tb_mem [256];
  bit tb_loaded = 1'b0;
  always @(posedge clock) begin
    if (!tb_loaded) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= (i == 16) ? 8'h5A : 8'h00;
      tb_loaded <= 1'b1;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_we) tb_mem[mem_adrs] <= mem_wdata;
      mem_rdata <= tb_mem[mem_adrs];
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: decide each cycle who must be served, what data comes back
  logic [7:0] ref_mem [256];
  bit   m_init = 1'b0;
  bit   m_cpu_ack, m_cpu_rd, m_hst_ack, m_hst_rd;
  logic [7:0] m_cpu_data, m_hst_data;
  int   m_wait;
  bit   e_cpu, e_hst;
  logic [7:0] e_adrs;

  always @(negedge clock) begin
    if (!m_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = (i == 16) ? 8'h5A : 8'h00;
      m_init = 1'b1;
      m_cpu_ack = 0; m_hst_ack = 0; m_wait = 0;
    end
    if (!reset_N) begin
      m_cpu_ack = 0; m_hst_ack = 0; m_wait = 0;
    end
    e_cpu = cpu_req && !hst_halt && (!hst_req || (LIMIT && m_wait >= HMAX));
    e_hst = hst_req && !e_cpu;
    e_adrs = e_cpu ? cpu_adrs : (e_hst ? hst_adrs : 8'h00);
    chk("m_cpu_gnt", cpu_gnt, e_cpu);
    chk("m_hst_gnt", hst_gnt, e_hst);
    chk("m_stall", cpu_stall, cpu_req && !e_cpu);
    chk("m_mem_adrs", mem_adrs, e_adrs);
    chk("m_mem_we", mem_we, (e_cpu && cpu_we) || (e_hst && hst_we));
    if (e_cpu && cpu_we) chk("m_mem_wdata", mem_wdata, cpu_wdata);
    if (e_hst && hst_we) chk("m_mem_wdata", mem_wdata, hst_wdata);
    chk("m_cpu_ack", cpu_ack, m_cpu_ack);
    chk("m_hst_ack", hst_ack, m_hst_ack);
    if (m_cpu_ack && m_cpu_rd) chk("m_cpu_rdata", cpu_rdata, m_cpu_data);
    if (m_hst_ack && m_hst_rd) chk("m_hst_rdata", hst_rdata, m_hst_data);
    if (reset_N) begin
      m_cpu_ack = e_cpu; m_cpu_rd = !cpu_we; m_cpu_data = ref_mem[cpu_adrs];
      m_hst_ack = e_hst; m_hst_rd = !hst_we; m_hst_data = ref_mem[hst_adrs];
      if (e_cpu && cpu_we) ref_mem[cpu_adrs] = cpu_wdata;
      if (e_hst && hst_we) ref_mem[hst_adrs] = hst_wdata;
      if (e_cpu || !cpu_req) m_wait = 0;
      else if (e_hst) m_wait++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int  hi, cyc, cgc, stalls, hbefore, hafter;
  bit  g_c, g_h, ack_seen;
  logic [7:0] ack_data;

  initial begin
    reset_N = 1'b0; hst_halt = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_adrs = 0; cpu_wdata = 0;
    hst_req = 0; hst_we = 0; hst_adrs = 0; hst_wdata = 0;
    repeat (3) @(posedge clock);
    #1 reset_N = 1'b1;
    @(negedge clock);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_hst_ack", hst_ack, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_adrs", mem_adrs, 0);
    step();

    // CPU read of preloaded 0x10
    cpu_req = 1; cpu_we = 0; cpu_adrs = 8'h10;
    @(negedge clock);
    chk("t1_gnt", cpu_gnt, 1);
    chk("t1_stall", cpu_stall, 0);
    step();
    cpu_req = 0;
    @(negedge clock);
    chk("t1_ack", cpu_ack, 1);
    chk("t1_rdata", cpu_rdata, 8'h5A);
    chk("t1_stall2", cpu_stall, 0);
    step();

    // Host streams writes 0..7 while the CPU waits to read 0x03
    hi = 0; cyc = 0; cgc = -1; stalls = 0; hbefore = 0; hafter = 0;
    ack_seen = 0; ack_data = 0;
    cpu_req = 1; cpu_we = 0; cpu_adrs = 8'h03;
    while ((hi < 8 || cpu_req) && cyc < 40) begin
      hst_req = (hi < 8); hst_we = 1;
      hst_adrs = 8'(hi); hst_wdata = 8'(hi);
      @(negedge clock);
      g_c = cpu_gnt; g_h = hst_gnt;
      if (cpu_stall) stalls++;
      if (cpu_ack) begin ack_seen = 1; ack_data = cpu_rdata; end
      if (g_c) cgc = cyc;
      if (g_h) begin
        if (cgc < 0) hbefore++;
        else hafter++;
      end
      step();
      if (g_h) hi++;
      if (g_c) cpu_req = 0;
      cyc++;
    end
    hst_req = 0; hst_we = 0;
    @(negedge clock);
    if (cpu_ack) begin ack_seen = 1; ack_data = cpu_rdata; end
    step();
    chk("t2_cpu_slot", 8'(cgc), LIMIT ? 8'd4 : 8'd8);
    chk("t2_h_before", 8'(hbefore), LIMIT ? 8'd4 : 8'd8);
    chk("t2_h_after", 8'(hafter), LIMIT ? 8'd4 : 8'd0);
    chk("t2_stalls", 8'(stalls), LIMIT ? 8'd4 : 8'd8);
    chk("t2_ack_seen", 8'(ack_seen), 1);
    chk("t2_rdata", ack_data, 8'h03);

    // Halt blocks the CPU; release grants it in the same cycle
    hst_halt = 1; cpu_req = 1; cpu_we = 0; cpu_adrs = 8'h10;
    repeat (3) begin
      @(negedge clock);
      chk("t3_halt_gnt", cpu_gnt, 0);
      chk("t3_halt_stall", cpu_stall, 1);
      step();
    end
    hst_halt = 0;
    @(negedge clock);
    chk("t3_rel_gnt", cpu_gnt, 1);
    step();
    hst_halt = 1;
    @(negedge clock);
    chk("t3_ack_kept", cpu_ack, 1);
    chk("t3_ack_rdata", cpu_rdata, 8'h5A);
    chk("t3_halt_gnt2", cpu_gnt, 0);
    step();
    hst_halt = 0; cpu_req = 0;
    step();

    // Same-address collision: host write first, CPU read sees it
    hst_req = 1; hst_we = 1; hst_adrs = 8'h20; hst_wdata = 8'hA5;
    cpu_req = 1; cpu_we = 0; cpu_adrs = 8'h20;
    @(negedge clock);
    chk("t4_hst_first", hst_gnt, 1);
    chk("t4_cpu_wait", cpu_gnt, 0);
    step();
    hst_req = 0; hst_we = 0;
    @(negedge clock);
    chk("t4_cpu_next", cpu_gnt, 1);
    chk("t4_hst_ack", hst_ack, 1);
    step();
    cpu_req = 0;
    @(negedge clock);
    chk("t4_ack", cpu_ack, 1);
    chk("t4_rdata", cpu_rdata, 8'hA5);
    step();

    // Reset right after a write and a read are accepted
    cpu_req = 1; cpu_we = 1; cpu_adrs = 8'h30; cpu_wdata = 8'h77;
    @(negedge clock);
    chk("t5_wr_gnt", cpu_gnt, 1);
    step();
    cpu_we = 0; cpu_adrs = 8'h10;
    @(negedge clock);
    chk("t5_rd_gnt", cpu_gnt, 1);
    step();
    cpu_req = 0; reset_N = 0;
    @(negedge clock);
    chk("t5_rst_ack", cpu_ack, 0);
    step();
    reset_N = 1;
    @(negedge clock);
    chk("t5_post_ack", cpu_ack, 0);
    chk("t5_post_hack", hst_ack, 0);
    chk("t5_post_we", mem_we, 0);
    chk("t5_post_adrs", mem_adrs, 0);
    step();
    cpu_req = 1; cpu_we = 0; cpu_adrs = 8'h30;
    step();
    cpu_req = 0;
    @(negedge clock);
    chk("t5_commit_ack", cpu_ack, 1);
    chk("t5_commit", cpu_rdata, 8'h77);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
